// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port
// with a pending-write scoreboard that drives reservation and read-hazard stalls.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                rsv_valid,
    input  logic [ADDR_W-1:0]   rsv_reg,
    output logic                rsv_stall,
    input  logic [ADDR_W-1:0]   rs_reg,
    input  logic [ADDR_W-1:0]   rt_reg,
    output logic                hazard_stall,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_reg,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy_vec
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

    src_t                last_grant;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                handshake;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                rsv_set;

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        alu_ready = alu_valid && (!mem_valid || last_grant == SRC_MEM);
        mem_ready = mem_valid && (!alu_valid || last_grant == SRC_ALU);
    end

    assign handshake = alu_ready || mem_ready;
    assign sel_reg   = alu_ready ? alu_reg  : mem_reg;
    assign sel_data  = alu_ready ? alu_data : mem_data;

    assign rsv_stall    = rsv_valid && busy[rsv_reg];
    assign rsv_set      = rsv_valid && !rsv_stall && (rsv_reg != '0);
    assign hazard_stall = ((rs_reg != '0) && busy[rs_reg]) ||
                          ((rt_reg != '0) && busy[rt_reg]);
    assign busy_vec     = busy;

    // Clear applied before set so a same-cycle reservation of the committing register survives.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_reg] = 1'b0;
        end
        if (rsv_set) begin
            busy_next[rsv_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_reg     <= '0;
            wr_data    <= '0;
            last_grant <= SRC_MEM;
            busy       <= '0;
        end else begin
            wr_en <= handshake && (sel_reg != '0);
            if (handshake) begin
                wr_reg     <= sel_reg;
                wr_data    <= sel_data;
                last_grant <= alu_ready ? SRC_ALU : SRC_MEM;
            end
            busy <= busy_next;
        end
    end

endmodule
